// File: rtl/ff_ram_bw.sv
// rtl/ff_ram_bw.sv - flip-flop RAM with byte masks, 1/2-cycle read latency and a clear engine
// Optional FF_RAM_BW_BYPASS_EN: same-edge write/read collisions return the merged (write-first) word.
module ff_ram_bw #(
    parameter int DW             = 32,
    parameter int AW             = 10,
    parameter int DEPTH          = 1024,
    parameter int READ_LAT       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                csb0,
    input  logic [DW/8-1:0]     wmask0,
    input  logic [AW-1:0]       addr0,
    input  logic [DW-1:0]       din0,
    input  logic                csb1,
    input  logic [AW-1:0]       addr1,
    output logic [DW-1:0]       dout1,
    input  logic                clr_req,
    output logic                busy
);

    localparam int NB = DW / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [IW-1:0] LAST_PTR = IW'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t          state, state_nxt;
    logic            start_q;
    logic [IW-1:0]   ptr, ptr_nxt;
    logic [DW-1:0]   mem [DEPTH];

    logic            wr_en;
    logic            rd_in_range;
    logic [IW-1:0]   wr_idx, rd_idx;
    logic [DW-1:0]   rd_word, rd_data;

    // start_q carries the auto-clear request across the reset release into the first edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            start_q <= (CLEAR_ON_RESET != 0);
            ptr     <= '0;
        end else begin
            state   <= state_nxt;
            start_q <= 1'b0;
            ptr     <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (start_q || clr_req) state_nxt = CLEAR;
            end
            CLEAR: begin
                if (ptr == LAST_PTR) begin
                    state_nxt = IDLE;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy        = (state == CLEAR);
    assign wr_en       = !csb0 && !busy && ({1'b0, addr0} < DEPTH_W);
    assign wr_idx      = addr0[IW-1:0];
    assign rd_in_range = ({1'b0, addr1} < DEPTH_W);
    assign rd_idx      = addr1[IW-1:0];

    // The array has no reset; only the clear engine zeroes it
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[ptr] <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < NB; k++) begin
                if (wmask0[k]) mem[wr_idx][8*k +: 8] <= din0[8*k +: 8];
            end
        end
    end

    assign rd_word = rd_in_range ? mem[rd_idx] : '0;

`ifdef FF_RAM_BW_BYPASS_EN
    always_comb begin
        rd_data = rd_word;
        if (wr_en && (addr0 == addr1)) begin
            for (int k = 0; k < NB; k++) begin
                if (wmask0[k]) rd_data[8*k +: 8] = din0[8*k +: 8];
            end
        end
    end
`else
    assign rd_data = rd_word;
`endif

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [DW-1:0] stage_q;
            logic          stage_v;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    stage_q <= '0;
                    stage_v <= 1'b0;
                    dout1   <= '0;
                end else begin
                    stage_v <= !csb1;
                    if (!csb1)  stage_q <= rd_data;
                    if (stage_v) dout1  <= stage_q;
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    dout1 <= '0;
                end else if (!csb1) begin
                    dout1 <= rd_data;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_ff_ram_bw.sv
// tb/tb_ff_ram_bw.sv - directed self-checking bench for ff_ram_bw (latency 1 and 2, auto-clear on/off)
module tb_ff_ram_bw;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            csb0, csb1, clr_req;
    logic [3:0]      wmask0;
    logic [AW-1:0]   addr0, addr1;
    logic [DW-1:0]   din0;
    logic [DW-1:0]   dout_l1, dout_l2, dout_nc;
    logic            busy_l1, busy_l2, busy_nc;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ff_ram_bw #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .READ_LAT(1), .CLEAR_ON_RESET(1)) u_l1 (
        .clk(clk), .reset_n(reset_n), .csb0(csb0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .csb1(csb1), .addr1(addr1), .dout1(dout_l1), .clr_req(clr_req), .busy(busy_l1));

    ff_ram_bw #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .READ_LAT(2), .CLEAR_ON_RESET(1)) u_l2 (
        .clk(clk), .reset_n(reset_n), .csb0(csb0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .csb1(csb1), .addr1(addr1), .dout1(dout_l2), .clr_req(clr_req), .busy(busy_l2));

    ff_ram_bw #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .READ_LAT(1), .CLEAR_ON_RESET(0)) u_nc (
        .clk(clk), .reset_n(reset_n), .csb0(csb0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .csb1(csb1), .addr1(addr1), .dout1(dout_nc), .clr_req(clr_req), .busy(busy_nc));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
        csb0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
        tick();
        csb0 = 1'b1;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy_l1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic fill_ones();
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), 32'hFFFF_FFFF, 4'hF);
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            csb1 = 1'b0; addr1 = AW'(i);
            tick();
            check({tag, "_l1"}, dout_l1, 32'h0);
            if (i > 0) check({tag, "_l2"}, dout_l2, 32'h0);
        end
        csb1 = 1'b1;
        tick();
        check({tag, "_l2_last"}, dout_l2, 32'h0);
    endtask

    initial begin
        int n;
        logic [31:0] exp_col, exp_part;

        reset_n = 1'b0; csb0 = 1'b1; csb1 = 1'b1; clr_req = 1'b0;
        wmask0 = '0; addr0 = '0; addr1 = '0; din0 = '0;
        tick(); tick();
        check("rst_dout_l1", dout_l1, 32'h0);
        check("rst_dout_l2", dout_l2, 32'h0);
        check("rst_busy_l1", {31'b0, busy_l1}, 32'h0);
        check("rst_busy_nc", {31'b0, busy_nc}, 32'h0);

        // Auto-clear after reset release
        reset_n = 1'b1;
        tick();
        check("auto_busy_l1", {31'b0, busy_l1}, 32'h1);
        check("auto_busy_l2", {31'b0, busy_l2}, 32'h1);
        check("auto_busy_nc", {31'b0, busy_nc}, 32'h0);
        count_busy(n);
        check("auto_clear_len", n, 32'd16);
        read_all_zero("auto_zero");

        // Byte masks and latency
        wr(5'd5, 32'hAABB_CCDD, 4'b1111);
        wr(5'd5, 32'h1122_3344, 4'b0101);
        csb1 = 1'b0; addr1 = 5'd5;
        tick();
        csb1 = 1'b1;
        check("mask_l1", dout_l1, 32'hAA22_CC44);
        check("lat2_edge_n", dout_l2, 32'h0);
        tick();
        check("lat2_edge_n1", dout_l2, 32'hAA22_CC44);

        // Zero mask and out-of-range accesses
        wr(5'd5, 32'h0, 4'b0000);
        wr(5'd21, 32'h5555_5555, 4'hF);
        csb1 = 1'b0; addr1 = 5'd5;
        tick();
        check("nomask_l1", dout_l1, 32'hAA22_CC44);
        addr1 = 5'd21;
        tick();
        csb1 = 1'b1;
        check("oor_rd_l1", dout_l1, 32'h0);
        check("oor_wr_l2", dout_l2, 32'hAA22_CC44);
        tick();
        check("oor_rd_l2", dout_l2, 32'h0);

        // Back-to-back reads
        for (int i = 1; i <= 4; i++) wr(AW'(i), 32'hC0DE_0000 + i, 4'hF);
        for (int i = 1; i <= 4; i++) begin
            csb1 = 1'b0; addr1 = AW'(i);
            tick();
            check("b2b_l1", dout_l1, 32'hC0DE_0000 + i);
            check("b2b_l2", dout_l2, (i == 1) ? 32'h0 : 32'hC0DE_0000 + i - 1);
        end
        csb1 = 1'b1; addr1 = 5'd5;
        tick();
        check("b2b_l2_tail", dout_l2, 32'hC0DE_0004);
        check("hold_l1", dout_l1, 32'hC0DE_0004);
        tick();
        check("hold_l2", dout_l2, 32'hC0DE_0004);

        // Collisions
`ifdef FF_RAM_BW_BYPASS_EN
        exp_col  = 32'hDEAD_BEEF;
        exp_part = 32'hDEAD_5678;
`else
        exp_col  = 32'h0;
        exp_part = 32'hDEAD_BEEF;
`endif
        csb0 = 1'b0; addr0 = 5'd7; din0 = 32'hDEAD_BEEF; wmask0 = 4'hF;
        csb1 = 1'b0; addr1 = 5'd7;
        tick();
        csb0 = 1'b1; csb1 = 1'b1;
        check("coll_l1", dout_l1, exp_col);
        tick();
        check("coll_l2", dout_l2, exp_col);
        csb0 = 1'b0; addr0 = 5'd7; din0 = 32'h1234_5678; wmask0 = 4'b0011;
        csb1 = 1'b0; addr1 = 5'd7;
        tick();
        csb0 = 1'b1;
        check("part_coll_l1", dout_l1, exp_part);
        tick();
        csb1 = 1'b1;
        check("part_after_l1", dout_l1, 32'hDEAD_5678);
        check("part_coll_l2", dout_l2, exp_part);
        tick();
        check("part_after_l2", dout_l2, 32'hDEAD_5678);

        // Clear interplay
        fill_ones();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check("clr_busy", {31'b0, busy_l1}, 32'h1);
        wr(5'd15, 32'h1234_5678, 4'hF);
        csb1 = 1'b0; addr1 = 5'd15;
        tick();
        csb1 = 1'b1;
        check("clr_rd_l1", dout_l1, 32'hFFFF_FFFF);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check("clr_rd_l2", dout_l2, 32'hFFFF_FFFF);
        count_busy(n);
        check("clr_len", n + 3, 32'd16);
        read_all_zero("clr_zero");

        // Reset mid-clear
        fill_ones();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        csb1 = 1'b0; addr1 = 5'd15;
        tick();
        csb1 = 1'b1;
        check("mid_rd_l1", dout_l1, 32'hFFFF_FFFF);
        tick();
        check("mid_rd_l2", dout_l2, 32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++) tick();
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'b0, busy_l1}, 32'h0);
        check("mid_rst_dout_l1", dout_l1, 32'h0);
        check("mid_rst_dout_l2", dout_l2, 32'h0);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        check("restart_busy_l1", {31'b0, busy_l1}, 32'h1);
        check("restart_busy_nc", {31'b0, busy_nc}, 32'h0);
        count_busy(n);
        check("restart_len", n, 32'd16);
        read_all_zero("restart_zero");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
